// File: rtl/zstr_arb_pkg.sv
// Shared types for the zstr round-robin arbiter.
// The grant lock is a two-state machine: free to re-arbitrate, or held on one requester.
package zstr_arb_pkg;

    typedef enum logic [0:0] {
        LCK_FREE = 1'b0,
        LCK_HELD = 1'b1
    } lck_e;

endpackage

// File: rtl/zstr_rr_pick.sv
// Rotating priority encoder: the first requester strictly after ptr_i, wrapping at RN.
// Returns index 0 when nothing is requesting.
module zstr_rr_pick #(
    parameter int RN  = 2,
    parameter int RNL = $clog2(RN)
) (
    input  logic [RN-1:0]  req_i,
    input  logic [RNL-1:0] ptr_i,
    output logic [RNL-1:0] sel_o,
    output logic           any_o
);

    logic [RN-1:0] hi_mask_s;
    logic [RN-1:0] hi_req_s;

    function automatic logic [RNL-1:0] lowest(input logic [RN-1:0] v);
        lowest = {RNL{1'b0}};
        for (int i = RN - 1; i >= 0; i--) begin
            lowest = v[i] ? RNL'(i) : lowest;
        end
    endfunction

    // Requests above the pointer win over wrapped ones below or at it.
    always_comb begin
        hi_mask_s = {RN{1'b0}};
        for (int i = 0; i < RN; i++) begin
            hi_mask_s[i] = (i > int'(ptr_i));
        end
        hi_req_s = req_i & hi_mask_s;
        any_o    = |req_i;
        sel_o    = (|hi_req_s) ? lowest(hi_req_s) : lowest(req_i);
    end

endmodule

// File: rtl/zstr_arb.sv
// Round-robin arbiter sharing one zstr stream among RN requesters, zero forward latency.
// The grant is held across stalls and, with PKT=1, across whole packets.
module zstr_arb
    import zstr_arb_pkg::*;
#(
    parameter int BW  = 8,
    parameter int RN  = 2,
    parameter int RNL = $clog2(RN),
    parameter int PKT = 0
) (
    input  logic              z_clk,
    input  logic              z_rst,
    input  logic [RN-1:0]     s_vld,
    input  logic [RN*BW-1:0]  s_bus,
    input  logic [RN-1:0]     s_lst,
    output logic [RN-1:0]     s_ack,
    output logic              m_vld,
    output logic [BW-1:0]     m_bus,
    output logic              m_lst,
    input  logic              m_ack,
    output logic [RNL-1:0]    m_sel
);

    localparam logic PKT_ON = (PKT != 32'sd0);

    lck_e           lck_q, lck_d;
    logic [RNL-1:0] ptr_q, ptr_d;
    logic [RNL-1:0] gnt_q, gnt_d;
    logic [RNL-1:0] pick_sel_s;
    logic           any_s;
    logic [RNL-1:0] sel_s;
    logic [BW-1:0]  bus_a [RN];

    zstr_rr_pick #(
        .RN  (RN),
        .RNL (RNL)
    ) u_pick (
        .req_i (s_vld),
        .ptr_i (ptr_q),
        .sel_o (pick_sel_s),
        .any_o (any_s)
    );

    // State register: lock, last-served pointer and locked index.
    always_ff @(posedge z_clk) begin
        if (z_rst) begin
            lck_q <= LCK_FREE;
            ptr_q <= RNL'(RN - 1);
            gnt_q <= {RNL{1'b0}};
        end else begin
            lck_q <= lck_d;
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
        end
    end

    // Next state: release on a completed transfer/packet, lock on stall or open packet.
    always_comb begin
        lck_d = lck_q;
        ptr_d = ptr_q;
        gnt_d = gnt_q;
        if (m_vld && m_ack) begin
            if (!PKT_ON || m_lst) begin
                lck_d = LCK_FREE;
                ptr_d = sel_s;
            end else begin
                lck_d = LCK_HELD;
                gnt_d = sel_s;
            end
        end else if (m_vld) begin
            lck_d = LCK_HELD;
            gnt_d = sel_s;
        end else if ((lck_q == LCK_HELD) && !PKT_ON) begin
            // Source dropped vld under a stall lock; recover instead of hanging.
            lck_d = LCK_FREE;
        end else begin
            lck_d = lck_q;
        end
    end

    // Outputs: route the selected requester straight through, ack back to it only.
    always_comb begin
        for (int i = 0; i < RN; i++) begin
            bus_a[i] = s_bus[i*BW +: BW];
        end
        case (lck_q)
            LCK_HELD: begin
                sel_s = gnt_q;
                m_vld = s_vld[gnt_q];
            end
            LCK_FREE: begin
                sel_s = pick_sel_s;
                m_vld = any_s;
            end
            default: begin
                sel_s = {RNL{1'b0}};
                m_vld = 1'b0;
            end
        endcase
        m_bus        = bus_a[sel_s];
        m_lst        = s_lst[sel_s];
        m_sel        = sel_s;
        s_ack        = {RN{1'b0}};
        s_ack[sel_s] = m_ack;
    end

endmodule

// File: tb/tb_zstr_arb.sv
// Bench for zstr_arb: two instances (RN=4, PKT=0 and PKT=1) under directed and random
// stimulus; a spec-level model queues per-cycle expectations that a monitor compares.
module tb_zstr_arb;

    localparam int RN = 4;
    localparam int BW = 8;

    typedef struct {
        bit         v;
        int         sel;
        logic [7:0] bus;
        bit         lst;
        logic [3:0] sack;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a  [2];
    logic [3:0]  vld_a  [2];
    logic [31:0] bus_a  [2];
    logic [3:0]  lst_a  [2];
    logic        ack_a  [2];
    logic [3:0]  sack_a [2];
    logic        mvld_a [2];
    logic [7:0]  mbus_a [2];
    logic        mlst_a [2];
    logic [1:0]  msel_a [2];

    logic        st_rst [2];
    logic [3:0]  st_vld [2];
    logic [31:0] st_bus [2];
    logic [3:0]  st_lst [2];
    logic        st_ack [2];

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   m_ptr [2];
    int   m_gnt [2];
    bit   m_lck [2];
    bit   rnd_mode = 1'b0;
    logic [3:0] got_ack [2];

    zstr_arb #(.BW(BW), .RN(RN), .PKT(0)) u_dut0 (
        .z_clk (clk),       .z_rst (rst_a[0]),
        .s_vld (vld_a[0]),  .s_bus (bus_a[0]),  .s_lst (lst_a[0]), .s_ack (sack_a[0]),
        .m_vld (mvld_a[0]), .m_bus (mbus_a[0]), .m_lst (mlst_a[0]),
        .m_ack (ack_a[0]),  .m_sel (msel_a[0])
    );

    zstr_arb #(.BW(BW), .RN(RN), .PKT(1)) u_dut1 (
        .z_clk (clk),       .z_rst (rst_a[1]),
        .s_vld (vld_a[1]),  .s_bus (bus_a[1]),  .s_lst (lst_a[1]), .s_ack (sack_a[1]),
        .m_vld (mvld_a[1]), .m_bus (mbus_a[1]), .m_lst (mlst_a[1]),
        .m_ack (ack_a[1]),  .m_sel (msel_a[1])
    );

    // Reference: pick by scanning ptr+1.. mod RN, then apply the lock/pointer rules.
    task automatic model(input int d);
        exp_t e;
        int   sel   = 0;
        bit   found = 1'b0;
        if (m_lck[d]) begin
            sel = m_gnt[d];
        end else begin
            for (int k = 1; k <= RN; k++) begin
                int c;
                c = (m_ptr[d] + k) % RN;
                if (!found && vld_a[d][c]) begin
                    sel   = c;
                    found = 1'b1;
                end
            end
        end
        e.v    = vld_a[d][sel];
        e.sel  = sel;
        e.bus  = bus_a[d][sel*8 +: 8];
        e.lst  = lst_a[d][sel];
        e.sack = ack_a[d] ? 4'(1 << sel) : 4'b0000;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (rst_a[d]) begin
            m_ptr[d] = RN - 1;
            m_lck[d] = 1'b0;
            m_gnt[d] = 0;
        end else if (e.v && ack_a[d]) begin
            if (d == 0 || e.lst) begin
                m_lck[d] = 1'b0;
                m_ptr[d] = sel;
            end else begin
                m_lck[d] = 1'b1;
                m_gnt[d] = sel;
            end
        end else if (e.v) begin
            m_lck[d] = 1'b1;
            m_gnt[d] = sel;
        end else if (m_lck[d] && d == 0) begin
            m_lck[d] = 1'b0;
        end
    endtask

    // Random sources: hold vld/bus until acked, otherwise maybe present a new word.
    task automatic rnd_src(input int d);
        for (int i = 0; i < RN; i++) begin
            if (st_vld[d][i] && !got_ack[d][i]) begin
                st_vld[d][i] = 1'b1;
            end else if ($urandom_range(0, 9) < 6) begin
                st_vld[d][i]         = 1'b1;
                st_bus[d][i*8 +: 8]  = 8'($urandom);
                st_lst[d][i]         = ($urandom_range(0, 2) == 0);
            end else begin
                st_vld[d][i] = 1'b0;
            end
        end
        st_ack[d] = ($urandom_range(0, 3) != 0);
        st_rst[d] = ($urandom_range(0, 63) == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rnd_mode) rnd_src(d);
            rst_a[d] = st_rst[d];
            vld_a[d] = st_vld[d];
            bus_a[d] = st_bus[d];
            lst_a[d] = st_lst[d];
            ack_a[d] = st_ack[d];
            model(d);
        end
    endtask

    task automatic set(input int d, input bit r, input logic [3:0] v, input logic [31:0] b,
                       input logic [3:0] l, input bit a);
        st_rst[d] = r;
        st_vld[d] = v;
        st_bus[d] = b;
        st_lst[d] = l;
        st_ack[d] = a;
    endtask

    task automatic chk(input int d, input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL dut%0d %s got=%0h want=%0h t=%0t", d, nm, got, want, $time);
        end
    endtask

    // Monitor: one expectation per DUT per cycle, sampled between edges.
    initial begin
        got_ack[0] = 4'b0000;
        got_ack[1] = 4'b0000;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                got_ack[d] = sack_a[d];
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk(d, "queue_empty", 32'd1, 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk(d, "m_vld", {31'd0, mvld_a[d]}, {31'd0, e.v});
                    chk(d, "m_sel", {30'd0, msel_a[d]}, 32'(e.sel));
                    chk(d, "s_ack", {28'd0, sack_a[d]}, {28'd0, e.sack});
                    if (e.v) begin
                        chk(d, "m_bus", {24'd0, mbus_a[d]}, {24'd0, e.bus});
                        chk(d, "m_lst", {31'd0, mlst_a[d]}, {31'd0, e.lst});
                    end
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            set(d, 1'b1, 4'b0000, 32'd0, 4'b0000, 1'b0);
            rst_a[d] = 1'b1; vld_a[d] = 4'b0000; bus_a[d] = 32'd0; lst_a[d] = 4'b0000; ack_a[d] = 1'b0;
            m_ptr[d] = RN - 1; m_gnt[d] = 0; m_lck[d] = 1'b0;
        end
        tick(); tick();
        set(0, 1'b0, 4'b0000, 32'd0, 4'b0000, 1'b0);
        set(1, 1'b0, 4'b0000, 32'd0, 4'b0000, 1'b0);
        tick();

        // PKT=0: alternation, stall lock, dropped-vld recovery, wrap-around.
        set(0, 1'b0, 4'b0011, 32'h0000_B1A0, 4'b0000, 1'b1);
        repeat (4) tick();
        set(0, 1'b0, 4'b0001, 32'h0000_B1A0, 4'b0000, 1'b0); tick();
        set(0, 1'b0, 4'b0011, 32'h0000_B1A0, 4'b0000, 1'b0); tick(); tick();
        set(0, 1'b0, 4'b0011, 32'h0000_B1A0, 4'b0000, 1'b1); tick(); tick();
        set(0, 1'b0, 4'b0001, 32'h0000_B2A1, 4'b0000, 1'b0); tick();
        set(0, 1'b0, 4'b0010, 32'h0000_B2A1, 4'b0000, 1'b0); tick();
        set(0, 1'b0, 4'b0010, 32'h0000_B2A1, 4'b0000, 1'b1); tick();
        set(0, 1'b1, 4'b0000, 32'd0, 4'b0000, 1'b0); tick();
        set(0, 1'b0, 4'b1001, 32'hD300_00A0, 4'b0000, 1'b1); repeat (3) tick();
        set(0, 1'b0, 4'b0000, 32'd0, 4'b0000, 1'b0);

        // PKT=1: contiguous packet with stall, then gap inside a packet, then reset mid-packet.
        set(1, 1'b1, 4'b0000, 32'd0, 4'b0000, 1'b0); tick();
        set(1, 1'b0, 4'b0011, 32'h0000_C1A0, 4'b0001, 1'b1); tick();
        tick();
        set(1, 1'b0, 4'b0011, 32'h0000_C2A0, 4'b0001, 1'b0); tick();
        set(1, 1'b0, 4'b0011, 32'h0000_C2A0, 4'b0001, 1'b1); tick();
        set(1, 1'b0, 4'b0011, 32'h0000_C3A0, 4'b0011, 1'b1); tick();
        set(1, 1'b0, 4'b0001, 32'h0000_C3A0, 4'b0001, 1'b1); tick();
        set(1, 1'b1, 4'b0000, 32'd0, 4'b0000, 1'b0); tick();
        set(1, 1'b0, 4'b0011, 32'h0000_B1A0, 4'b0000, 1'b1); tick();
        set(1, 1'b0, 4'b0010, 32'h0000_B1A0, 4'b0000, 1'b1); tick(); tick();
        set(1, 1'b0, 4'b0011, 32'h0000_B1A5, 4'b0001, 1'b1); tick();
        set(1, 1'b0, 4'b0010, 32'h0000_B1A5, 4'b0001, 1'b1); tick();
        set(1, 1'b1, 4'b0000, 32'd0, 4'b0000, 1'b0); tick();
        set(1, 1'b0, 4'b0001, 32'h0000_B1A0, 4'b0001, 1'b1); tick();
        set(1, 1'b0, 4'b0010, 32'h0000_B1A0, 4'b0000, 1'b1); tick();
        set(1, 1'b1, 4'b0011, 32'h0000_B2A0, 4'b0001, 1'b0); tick();
        set(1, 1'b0, 4'b0011, 32'h0000_B2A0, 4'b0001, 1'b1); tick();
        set(1, 1'b0, 4'b0010, 32'h0000_B2A0, 4'b0001, 1'b1); tick();
        set(1, 1'b0, 4'b0000, 32'd0, 4'b0000, 1'b0); tick();

        rnd_mode = 1'b1;
        repeat (3000) tick();
        rnd_mode = 1'b0;
        set(0, 1'b0, 4'b0000, 32'd0, 4'b0000, 1'b0);
        set(1, 1'b0, 4'b0000, 32'd0, 4'b0000, 1'b0);
        tick();
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
